// File: rtl/qspi_packet_rx_pkg.sv
// Shared types and constants for the QSPI packet receiver.
// The FSM encoding and word geometry live here so the top and bench agree.
package qspi_pkg;
    localparam int NIBBLES_PER_WORD = 8;
    localparam int WORD_WIDTH       = 32;
    localparam int CNT_W            = 3;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2,
        DONE      = 2'd3
    } state_e;
endpackage

// File: rtl/qspi_rx_fifo.sv
// Word FIFO, DEPTH x 32; head visible on pop_dat_o, zero when empty.
// Push is accepted when not full, or when full with a pop in the same cycle.
module qspi_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_vld_i,
    input  logic [31:0] push_dat_i,
    input  logic        pop_rdy_i,
    output logic        pop_vld_o,
    output logic [31:0] pop_dat_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        pop, push_ok;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_vld_o = !empty_o;
    assign pop_dat_o = empty_o ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign pop       = pop_vld_o && pop_rdy_i;
    assign push_ok   = push_vld_i && (!full_o || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// File: rtl/qspi_packet_rx.sv
// QSPI nibble receiver: synchronizes CS/SCLK/data, assembles 8 nibbles per word, queues words.
// Word pushed at the end of the cycle the 8th SCLK rise is seen; dropped with an overflow pulse when full.
module qspi_packet_rx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        qspi_cs,
    input  logic        qspi_clk,
    input  logic [3:0]  qspi_data,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [7:0]  word_count
);
    import qspi_pkg::*;

    logic [SYNC_STAGES-1:0]      cs_sync_q, sclk_sync_q, warm_q;
    logic [SYNC_STAGES-1:0][3:0] data_sync_q;
    logic                        sclk_prev_q;
    logic                        cs_s, sclk_s, rise, warm;
    logic [3:0]                  data_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic                   push, ferr_d;
    logic                   fifo_full, fifo_empty, pop, push_ok;
    logic                   frame_err_q, overflow_q;
    logic [7:0]             word_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            warm_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], qspi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], qspi_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], qspi_data};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s && !sclk_prev_q;
    // The reset value of the CS synchronizer is not a real observation of the pin;
    // WAIT_HIGH only trusts cs once a sampled value has reached the last stage.
    assign warm   = warm_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_HIGH: if (warm && cs_s) state_d = IDLE;
            IDLE:      if (!cs_s) state_d = RECV;
            RECV: begin
                if (cs_s)                                  state_d = IDLE;
                else if (rise && cnt_q == CNT_W'(NIBBLES_PER_WORD - 1)) state_d = DONE;
            end
            DONE:      if (cs_s) state_d = IDLE;
            default:   state_d = WAIT_HIGH;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (cs_s) begin
                    ferr_d = (cnt_q != '0);
                end else if (rise) begin
                    shift_d = {shift_q[WORD_WIDTH-5:0], data_s};
                    cnt_d   = cnt_q + 1'b1;
                    push    = (cnt_q == CNT_W'(NIBBLES_PER_WORD - 1));
                end
            end
            default: ;
        endcase
    end

    assign pop     = rx_valid && rx_ready;
    assign push_ok = push && (!fifo_full || pop);

    qspi_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (push),
        .push_dat_i (shift_d),
        .pop_rdy_i  (rx_ready),
        .pop_vld_o  (rx_valid),
        .pop_dat_o  (rx_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            frame_err_q  <= ferr_d;
            overflow_q   <= push && !push_ok;
            if (push_ok) word_count_q <= word_count_q + 8'd1;
        end
    end

    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

    logic unused_empty;
    assign unused_empty = fifo_empty;
endmodule
